motor_pwm_ramp: RTL and testbench
=================================

// Module: motor_pwm_ramp
// PURPOSE
//  Multi-channel counter-based motor PWM generator with button speed selection and soft-start/stop ramping.
//  Two debounced buttons select one of four speed levels. Each enabled channel ramps its duty toward that level's target.
//  Sits between the board buttons/LEDs and the motor driver inputs; replaces fixed-pattern PWM with programmable resolution.
// PARAMETERS
//  NUM_CH          2       number of motor channels (>=1)
//  PWM_WIDTH       8       PWM counter/duty width; period = 2**PWM_WIDTH ticks
//  PRESCALE        256     clk cycles per PWM tick (>=1)
//  DEBOUNCE_CYCLES 100000  stable cycles required before a button change is accepted
//  DUTY_SLOW       64      target duty, button A only
//  DUTY_FAST       128     target duty, button B only
//  DUTY_FASTEST    192     target duty, both buttons
//  RAMP_STEP       4       max duty change per PWM period (>=1)
// PORTS
//  clk          in   1          system clock
//  reset        in   1          asynchronous, active-high reset
//  button_a     in   1          raw async button (slow)
//  button_b     in   1          raw async button (fast)
//  ch_enable    in   NUM_CH     per-channel run enable, synchronous to clk
//  motor_pwm    out  NUM_CH     registered PWM outputs
//  speed_leds   out  3          000 stop / 001 slow / 011 fast / 111 fastest
//  at_speed     out  1          every enabled channel's duty == target
// BEHAVIOUR
//  Reset (async assert, sync-safe deassert): all counters 0, duties 0, state STOP, motor_pwm=0, speed_leds=000, at_speed=1.
//  Buttons: 2-flop synchroniser, then counter debounce.
//   - Counter clears on any change of the synchronised level.
//   - Clean level updates when it has been stable DEBOUNCE_CYCLES cycles.
//  Speed state {b,a}: 00 STOP(target 0), 01 SLOW, 10 FAST, 11 FASTEST.
//   - Registered 1 cycle after the clean levels; speed_leds registered from the state.
//  Prescaler: counts 0..PRESCALE-1; tick on PRESCALE-1. PRESCALE=1 gives a tick every cycle.
//  pwm_cnt: PWM_WIDTH bits, increments on tick, wraps 2**W-1 -> 0. The tick causing the wrap is period_end.
//  Per channel: motor_pwm[i] <= (pwm_cnt < duty[i]), registered.
//   - duty 0 = constant low; duty 2**W-1 = high for all but one tick.
//  Ramp, at period_end only (glitch-free):
//   - duty += min(RAMP_STEP, target-duty) when below target.
//   - duty -= min(RAMP_STEP, duty-target) when above target.
//   - Never overshoots; saturates at target.
//  Target change mid-period takes effect at the next period_end.
//  ch_enable[i]=0: duty[i] cleared to 0 immediately and motor_pwm[i]=0 next cycle (hard stop, no ramp).
//   - Re-enable restarts the ramp from 0 at the next period_end.
//  at_speed: registered; AND over enabled channels of (duty==target); 1 when no channel is enabled.
//  Targets wider than PWM_WIDTH are truncated. DUTY_* values must be < 2**PWM_WIDTH; an elaboration check enforces this.
// CONFIGURATION
//  MOTOR_PWM_ESTOP_EN defined: adds input estop (1 bit, sync).
//   - estop=1 zeroes all duties and outputs next cycle and sets a latched fault.
//   - While latched, targets are forced to 0 and speed_leds=100.
//   - Latch clears only when estop=0 and both clean buttons are released.
//  MOTOR_PWM_ESTOP_EN undefined: no estop port, no fault latch; speed_leds never shows 100.
// STRUCTURE
//  Package motor_pkg: speed_state_t enum {SPEED_STOP,SPEED_SLOW,SPEED_FAST,SPEED_FASTEST} (2 bits), LED encoding constants.
//  Sub-module button_debounce (DEBOUNCE_CYCLES param; clk, reset, raw, clean), instantiated per button.
//  Duty/ramp logic in a generate loop over NUM_CH.
// TESTING  (NUM_CH=2, PWM_WIDTH=4, PRESCALE=1, DEBOUNCE_CYCLES=4, RAMP_STEP=2, DUTY_SLOW=4, DUTY_FAST=8, DUTY_FASTEST=12)
//  1 Reset mid-run with outputs high -> motor_pwm=00, speed_leds=000 asynchronously; at_speed=1.
//  2 button_a glitch of 3 cycles -> state stays STOP. Hold 6+ cycles -> speed_leds=001.
//    Duties go 2,4 on successive period_ends; then at_speed=1 and 4/16 high duty.
//  3 A+B from SLOW -> duty 4,6,8,10,12 per period; speed_leds=111; release both -> ramps down by 2 to 0.
//  4 RAMP_STEP=3, target 8 from 4 -> duties 7,8 (no overshoot to 10).
//  5 ch_enable=01 while FAST -> motor_pwm[1]=0 next cycle, ch0 unaffected, at_speed from ch0 only.
//    Re-enable -> ch1 ramps 2,4,...
//  6 (MOTOR_PWM_ESTOP_EN) estop pulse while FASTEST -> all outputs 0, speed_leds=100.
//    Stays latched until both buttons released; then ramps normally.

Source files
------------

// File: rtl/motor_pwm_ramp_pkg.sv
// Shared types and LED encodings for the motor PWM ramp generator.
package motor_pkg;

    typedef enum logic [1:0] {
        SPEED_STOP    = 2'b00,
        SPEED_SLOW    = 2'b01,
        SPEED_FAST    = 2'b10,
        SPEED_FASTEST = 2'b11
    } speed_state_t;

    localparam logic [2:0] LED_STOP    = 3'b000;
    localparam logic [2:0] LED_SLOW    = 3'b001;
    localparam logic [2:0] LED_FAST    = 3'b011;
    localparam logic [2:0] LED_FASTEST = 3'b111;
    localparam logic [2:0] LED_FAULT   = 3'b100;

    function automatic logic [2:0] speed_leds_of(input speed_state_t s);
        case (s)
            SPEED_SLOW:    return LED_SLOW;
            SPEED_FAST:    return LED_FAST;
            SPEED_FASTEST: return LED_FASTEST;
            default:       return LED_STOP;
        endcase
    endfunction

endpackage

// File: rtl/motor_pwm_ramp_debounce.sv
// Button conditioner: two-flop synchroniser followed by a stability counter.
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 100000
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic clean
);

    localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          meta_q, sync_q;
    logic          clean_q, clean_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q  <= 1'b0;
            sync_q  <= 1'b0;
            clean_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            meta_q  <= raw;
            sync_q  <= meta_q;
            clean_q <= clean_d;
            cnt_q   <= cnt_d;
        end
    end

    // Counter only runs while the synchronised level disagrees with the accepted one,
    // so any bounce back to the accepted level clears it.
    // NOTE: every always_comb output gets a default first, otherwise a latch is inferred.
    always_comb begin
        cnt_d   = '0;
        clean_d = clean_q;
        if (sync_q != clean_q) begin
            if (cnt_q == CNT_LAST) begin
                clean_d = sync_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    assign clean = clean_q;

endmodule

// File: rtl/motor_pwm_ramp.sv
// Multi-channel motor PWM with debounced speed buttons and soft-start/stop ramping.
// Optional emergency stop with latched fault when MOTOR_PWM_ESTOP_EN is defined.
module motor_pwm_ramp
    import motor_pkg::*;
#(
    parameter int NUM_CH          = 2,
    parameter int PWM_WIDTH       = 8,
    parameter int PRESCALE        = 256,
    parameter int DEBOUNCE_CYCLES = 100000,
    parameter int DUTY_SLOW       = 64,
    parameter int DUTY_FAST       = 128,
    parameter int DUTY_FASTEST    = 192,
    parameter int RAMP_STEP       = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              button_a,
    input  logic              button_b,
    input  logic [NUM_CH-1:0] ch_enable,
`ifdef MOTOR_PWM_ESTOP_EN
    input  logic              estop,
`endif
    output logic [NUM_CH-1:0] motor_pwm,
    output logic [2:0]        speed_leds,
    output logic              at_speed
);

    if (DUTY_SLOW >= 2**PWM_WIDTH || DUTY_FAST >= 2**PWM_WIDTH || DUTY_FASTEST >= 2**PWM_WIDTH
        || NUM_CH < 1 || PRESCALE < 1 || RAMP_STEP < 1) begin : g_bad_params
        $error("motor_pwm_ramp: illegal parameter combination");
    end

    localparam int                   PW         = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]        PRESC_LAST = PW'(PRESCALE - 1);
    localparam logic [PWM_WIDTH-1:0] CNT_MAX    = '1;
    localparam logic [PWM_WIDTH-1:0] TGT_SLOW   = PWM_WIDTH'(DUTY_SLOW);
    localparam logic [PWM_WIDTH-1:0] TGT_FAST   = PWM_WIDTH'(DUTY_FAST);
    localparam logic [PWM_WIDTH-1:0] TGT_FSTST  = PWM_WIDTH'(DUTY_FASTEST);
    localparam int                   STEP_SAT   = (RAMP_STEP >= 2**PWM_WIDTH) ? 2**PWM_WIDTH - 1 : RAMP_STEP;
    localparam logic [PWM_WIDTH-1:0] STEP_V     = PWM_WIDTH'(STEP_SAT);

    logic                 clean_a, clean_b;
    speed_state_t         state_q, state_d;
    logic [2:0]           leds_q, leds_d;
    logic [PW-1:0]        presc_q, presc_d;
    logic [PWM_WIDTH-1:0] pwm_cnt_q, pwm_cnt_d;
    logic                 tick, period_end;
    logic [PWM_WIDTH-1:0] target;
    logic [NUM_CH-1:0]    duty_match;
    logic                 at_speed_q, at_speed_d;
    logic                 fault_q;
    logic                 kill;

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_a (
        .clk(clk), .reset(reset), .raw(button_a), .clean(clean_a)
    );
    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_b (
        .clk(clk), .reset(reset), .raw(button_b), .clean(clean_b)
    );

`ifdef MOTOR_PWM_ESTOP_EN
    logic fault_d;
    assign kill    = estop;
    // Fault holds until estop is gone and the operator has let go of both buttons.
    assign fault_d = estop | (fault_q & (clean_a | clean_b));
    always_ff @(posedge clk or posedge reset) begin
        if (reset) fault_q <= 1'b0;
        else       fault_q <= fault_d;
    end
`else
    assign kill    = 1'b0;
    assign fault_q = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= SPEED_STOP;
            leds_q     <= LED_STOP;
            presc_q    <= '0;
            pwm_cnt_q  <= '0;
            at_speed_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            leds_q     <= leds_d;
            presc_q    <= presc_d;
            pwm_cnt_q  <= pwm_cnt_d;
            at_speed_q <= at_speed_d;
        end
    end

    always_comb begin
        state_d    = speed_state_t'({clean_b, clean_a});
        leds_d     = fault_q ? LED_FAULT : speed_leds_of(state_q);
        at_speed_d = &(duty_match | ~ch_enable);
        target     = '0;
        if (!fault_q) begin
            case (state_q)
                SPEED_SLOW:    target = TGT_SLOW;
                SPEED_FAST:    target = TGT_FAST;
                SPEED_FASTEST: target = TGT_FSTST;
                default:       target = '0;
            endcase
        end
    end

    assign tick       = (presc_q == PRESC_LAST);
    assign period_end = tick && (pwm_cnt_q == CNT_MAX);

    always_comb begin
        presc_d   = tick ? '0 : presc_q + 1'b1;
        pwm_cnt_d = tick ? pwm_cnt_q + 1'b1 : pwm_cnt_q;
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [PWM_WIDTH-1:0] duty_q, duty_d;
        logic                 pwm_q;

        // Duty only moves on the wrap so a period is never cut short or stretched.
        always_comb begin
            duty_d = duty_q;
            if (!ch_enable[i] || kill) begin
                duty_d = '0;
            end else if (period_end) begin
                if (duty_q < target) begin
                    duty_d = (target - duty_q > STEP_V) ? duty_q + STEP_V : target;
                end else if (duty_q > target) begin
                    duty_d = (duty_q - target > STEP_V) ? duty_q - STEP_V : target;
                end
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                duty_q <= '0;
                pwm_q  <= 1'b0;
            end else begin
                duty_q <= duty_d;
                pwm_q  <= ch_enable[i] && !kill && (pwm_cnt_q < duty_q);
            end
        end

        assign motor_pwm[i]  = pwm_q;
        assign duty_match[i] = (duty_q == target);
    end

    assign speed_leds = leds_q;
    assign at_speed   = at_speed_q;

endmodule

// File: tb/tb_motor_pwm_ramp.sv
// Directed bench: duties are recovered from the width of each PWM high pulse.
module tb_motor_pwm_ramp;

    logic       clk = 1'b0;
    logic       reset;
    logic       btn_a, btn_b, b2_a, b2_b;
    logic [1:0] ch_en;
    logic [1:0] pwm, pwm2;
    logic [2:0] leds, leds2;
    logic       at_spd, at_spd2;
`ifdef MOTOR_PWM_ESTOP_EN
    logic       estop = 1'b0;
`endif

    always #5 clk = ~clk;

    motor_pwm_ramp #(
        .NUM_CH(2), .PWM_WIDTH(4), .PRESCALE(1), .DEBOUNCE_CYCLES(4),
        .DUTY_SLOW(4), .DUTY_FAST(8), .DUTY_FASTEST(12), .RAMP_STEP(2)
    ) dut (
        .clk(clk), .reset(reset), .button_a(btn_a), .button_b(btn_b),
        .ch_enable(ch_en),
`ifdef MOTOR_PWM_ESTOP_EN
        .estop(estop),
`endif
        .motor_pwm(pwm), .speed_leds(leds), .at_speed(at_spd)
    );

    motor_pwm_ramp #(
        .NUM_CH(2), .PWM_WIDTH(4), .PRESCALE(1), .DEBOUNCE_CYCLES(4),
        .DUTY_SLOW(4), .DUTY_FAST(8), .DUTY_FASTEST(12), .RAMP_STEP(3)
    ) dut3 (
        .clk(clk), .reset(reset), .button_a(b2_a), .button_b(b2_b),
        .ch_enable(2'b11),
`ifdef MOTOR_PWM_ESTOP_EN
        .estop(1'b0),
`endif
        .motor_pwm(pwm2), .speed_leds(leds2), .at_speed(at_spd2)
    );

    typedef struct packed {
        logic             a;
        logic             b;
        logic [2:0]       leds;
        logic [3:0][3:0]  duty;     // duty[0] is the first period after the LED change
        logic             at_speed;
    } vec_t;

    vec_t vecs[4];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   up_seq[5]   = '{6, 8, 10, 12, 12};
    int   fast_seq[3] = '{10, 8, 8};
    int   ren_seq[4]  = '{2, 4, 6, 8};

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual == expected) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    function automatic logic pwm_sel(input int sel);
        case (sel)
            0:       return pwm[0];
            1:       return pwm[1];
            default: return pwm2[0];
        endcase
    endfunction

    // Width of the next complete high pulse; 0 if no pulse starts within 40 cycles.
    task automatic measure(input int sel, output int duty);
        logic prev, cur;
        bit   seen;
        int   high;
        duty = 0;
        seen = 0;
        @(negedge clk);
        prev = pwm_sel(sel);
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            cur = pwm_sel(sel);
            if (!prev && cur) seen = 1;
            prev = cur;
        end
        if (seen) begin
            high = 1;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (pwm_sel(sel)) high++;
                else break;
            end
            duty = high;
        end
    endtask

    task automatic wait_leds(input int sel, input logic [2:0] val, input string name);
        logic [2:0] cur;
        cur = (sel == 0) ? leds : leds2;
        for (int i = 0; i < 60 && cur != val; i++) begin
            @(negedge clk);
            cur = (sel == 0) ? leds : leds2;
        end
        check(name, int'(cur), int'(val));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int   d;
        int   high;
        logic found;

        vecs[0] = '{a: 1'b1, b: 1'b0, leds: 3'b001, duty: {4'd4,  4'd4,  4'd4,  4'd3},  at_speed: 1'b1};
        vecs[1] = '{a: 1'b0, b: 1'b1, leds: 3'b011, duty: {4'd8,  4'd8,  4'd8,  4'd7},  at_speed: 1'b1};
        vecs[2] = '{a: 1'b1, b: 1'b1, leds: 3'b111, duty: {4'd12, 4'd12, 4'd12, 4'd11}, at_speed: 1'b1};
        vecs[3] = '{a: 1'b0, b: 1'b0, leds: 3'b000, duty: {4'd0,  4'd3,  4'd6,  4'd9},  at_speed: 1'b1};

        reset = 1'b1;
        btn_a = 1'b0; btn_b = 1'b0; b2_a = 1'b0; b2_b = 1'b0;
        ch_en = 2'b11;
        #1;
        check("reset pwm", int'(pwm), 0);
        check("reset leds", int'(leds), 0);
        check("reset at_speed", int'(at_spd), 1);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        // Short glitch must be rejected, a long press accepted.
        btn_a = 1'b1;
        repeat (3) @(negedge clk);
        btn_a = 1'b0;
        repeat (12) @(negedge clk);
        check("glitch ignored leds", int'(leds), 0);
        btn_a = 1'b1;
        wait_leds(0, 3'b001, "slow leds");
        check("slow at_speed low", int'(at_spd), 0);
        measure(0, d); check("slow duty p1", d, 2);
        measure(0, d); check("slow duty p2", d, 4);
        measure(0, d); check("slow duty p3", d, 4);
        check("slow at_speed", int'(at_spd), 1);
        measure(1, d); check("slow ch1 duty", d, 4);

        btn_b = 1'b1;
        wait_leds(0, 3'b111, "fastest leds");
        for (int k = 0; k < 5; k++) begin
            measure(0, d);
            check($sformatf("ramp up p%0d", k), d, up_seq[k]);
        end
        check("fastest at_speed", int'(at_spd), 1);

        btn_a = 1'b0;
        wait_leds(0, 3'b011, "fast leds");
        for (int k = 0; k < 3; k++) begin
            measure(0, d);
            check($sformatf("ramp down p%0d", k), d, fast_seq[k]);
        end

        // Hard stop of channel 1 while its output is high.
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            found = pwm[1];
        end
        check("ch1 high before disable", int'(found), 1);
        ch_en = 2'b01;
        @(negedge clk);
        check("ch1 hard stop", int'(pwm[1]), 0);
        high = 0;
        repeat (20) begin
            @(negedge clk);
            if (pwm[1]) high++;
        end
        check("ch1 stays low", high, 0);
        measure(0, d); check("ch0 unaffected", d, 8);
        check("at_speed ch0 only", int'(at_spd), 1);
        ch_en = 2'b11;
        @(negedge clk);
        check("re-enable at_speed low", int'(at_spd), 0);
        for (int k = 0; k < 4; k++) begin
            measure(1, d);
            check($sformatf("ch1 restart p%0d", k), d, ren_seq[k]);
        end

        // Asynchronous reset while both outputs are driving.
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            found = (pwm == 2'b11);
        end
        check("both high before reset", int'(found), 1);
        #2 reset = 1'b1;
        btn_a = 1'b0; btn_b = 1'b0;
        #1;
        check("async reset pwm", int'(pwm), 0);
        check("async reset leds", int'(leds), 0);
        check("async reset at_speed", int'(at_spd), 1);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);

`ifdef MOTOR_PWM_ESTOP_EN
        btn_a = 1'b1; btn_b = 1'b1;
        wait_leds(0, 3'b111, "estop pre leds");
        repeat (6) measure(0, d);
        check("estop pre duty", d, 12);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            found = pwm[0];
        end
        check("ch0 high before estop", int'(found), 1);
        estop = 1'b1;
        @(negedge clk);
        estop = 1'b0;
        check("estop outputs", int'(pwm), 0);
        @(negedge clk);
        check("estop leds", int'(leds), 4);
        high = 0;
        repeat (40) begin
            @(negedge clk);
            if (pwm != 2'b00) high++;
        end
        check("estop latched outputs", high, 0);
        check("estop latched leds", int'(leds), 4);
        btn_a = 1'b0; btn_b = 1'b0;
        wait_leds(0, 3'b000, "estop cleared leds");
        btn_a = 1'b1;
        wait_leds(0, 3'b001, "post estop leds");
        measure(0, d); check("post estop duty", d, 2);
        btn_a = 1'b0;
`endif

        // Speed table on the RAMP_STEP=3 instance, including the no-overshoot case.
        for (int r = 0; r < 4; r++) begin
            @(negedge clk);
            b2_a = vecs[r].a;
            b2_b = vecs[r].b;
            wait_leds(1, vecs[r].leds, $sformatf("vec%0d leds", r));
            for (int k = 0; k < 4; k++) begin
                measure(2, d);
                check($sformatf("vec%0d duty p%0d", r, k), d, int'(vecs[r].duty[k]));
            end
            check($sformatf("vec%0d at_speed", r), int'(at_spd2), int'(vecs[r].at_speed));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
